// File: rtl/stim_pkg.sv
// Shared types, constants and the Galois LFSR step used by the stim_gen stimulus source.
package stim_pkg;

    localparam int unsigned LFSR_WIDTH  = 32;
    localparam logic [LFSR_WIDTH-1:0] LFSR_POLY = 32'h80200003;
    localparam int unsigned COUNT_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        DIR0,
        DIR1,
        RAND,
        FLUSH,
        DONE
    } stim_state_t;

    // Right-shifting Galois form: feedback taps are applied when the bit shifted out is 1.
    function automatic logic [LFSR_WIDTH-1:0] lfsr_next(input logic [LFSR_WIDTH-1:0] v);
        return v[0] ? ((v >> 1) ^ LFSR_POLY) : (v >> 1);
    endfunction

endpackage

// File: rtl/stim_gen_lfsr32.sv
// 32-bit Galois LFSR; load (or reset) takes the seed, step advances one position.
module lfsr32
    import stim_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  step,
    input  logic [LFSR_WIDTH-1:0] seed,
    output logic [LFSR_WIDTH-1:0] value
);

    always_ff @(posedge clk) begin
        if (reset || load) begin
            value <= seed;
        end else if (step) begin
            value <= lfsr_next(value);
        end
    end

endmodule

// File: rtl/stim_gen.sv
// Stimulus source: all-ones, all-zeros, then LFSR vectors, with a LATENCY-deep expected-value pipe.
// Optional feature macro: STIM_ERR_INJECT_EN (corrupts exp_data bit 0 of vector INJECT_IDX).
module stim_gen
    import stim_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 1,
    parameter int unsigned NUM_RANDOM = 10,
    parameter int unsigned LATENCY    = 1,
    parameter logic [31:0] LFSR_SEED  = 32'hACE12345,
    parameter int unsigned INJECT_IDX = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   stall,
    output logic [DATA_WIDTH-1:0]  stim_data,
    output logic                   stim_valid,
    output logic                   exp_valid,
    output logic [DATA_WIDTH-1:0]  exp_data,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] vec_count
);

    localparam logic [COUNT_WIDTH-1:0] RAND_LAST  = COUNT_WIDTH'(NUM_RANDOM - 1);
    localparam logic [31:0]            FLUSH_LAST = 32'(LATENCY - 1);

    stim_state_t            state;
    logic [COUNT_WIDTH-1:0] rand_cnt;
    logic [31:0]            flush_cnt;
    logic [LFSR_WIDTH-1:0]  lfsr_value;
    logic                   issuing;
    logic                   start_ok;
    logic [DATA_WIDTH-1:0]  pipe_in_data;
    logic                   unused_cfg;

    always_comb begin
        issuing  = (state == DIR0 || state == DIR1 || state == RAND) && !stall;
        start_ok = (state == IDLE || state == DONE) && start;
    end

    lfsr32 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .load  (start_ok),
        .step  (issuing && state == RAND),
        .seed  (LFSR_SEED),
        .value (lfsr_value)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            stim_valid <= 1'b0;
            stim_data  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            vec_count  <= '0;
            rand_cnt   <= '0;
            flush_cnt  <= '0;
        end else begin
            stim_valid <= issuing;
            if (issuing && vec_count != '1) begin
                vec_count <= vec_count + 1'b1;
            end
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= DIR0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        vec_count <= '0;
                    end
                end
                DIR0: begin
                    if (!stall) begin
                        stim_data <= '1;
                        state     <= DIR1;
                    end
                end
                DIR1: begin
                    if (!stall) begin
                        stim_data <= '0;
                        rand_cnt  <= '0;
                        state     <= RAND;
                    end
                end
                RAND: begin
                    if (!stall) begin
                        stim_data <= lfsr_value[DATA_WIDTH-1:0];
                        if (rand_cnt == RAND_LAST) begin
                            flush_cnt <= '0;
                            state     <= FLUSH;
                        end else begin
                            rand_cnt <= rand_cnt + 1'b1;
                        end
                    end
                end
                FLUSH: begin
                    // Counts the cycles the last vector needs to drain through the exp pipe.
                    if (flush_cnt == FLUSH_LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef STIM_ERR_INJECT_EN
    logic stim_inject;

    // vec_count still holds the index of the vector being issued on this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            stim_inject <= 1'b0;
        end else begin
            stim_inject <= issuing && (32'(vec_count) == 32'(INJECT_IDX));
        end
    end

    assign pipe_in_data = stim_data ^ DATA_WIDTH'(stim_inject);
    assign unused_cfg   = ^lfsr_value;
`else
    assign pipe_in_data = stim_data;
    assign unused_cfg   = ^{lfsr_value, INJECT_IDX};
`endif

    logic                  exp_v_pipe [LATENCY];
    logic [DATA_WIDTH-1:0] exp_d_pipe [LATENCY];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                exp_v_pipe[i] <= 1'b0;
                exp_d_pipe[i] <= '0;
            end
        end else begin
            exp_v_pipe[0] <= stim_valid;
            exp_d_pipe[0] <= pipe_in_data;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                exp_v_pipe[i] <= exp_v_pipe[i-1];
                exp_d_pipe[i] <= exp_d_pipe[i-1];
            end
        end
    end

    assign exp_valid = exp_v_pipe[LATENCY-1];
    assign exp_data  = exp_d_pipe[LATENCY-1];

endmodule
